imm_extend_unit: RTL and testbench
==================================

// Module: imm_extend_unit
// PURPOSE
//  Registered, parametrised immediate generator between decode and the ALU operand mux.
//  Joins the upper/lower instruction fields into one IN_W-bit field.
//  Extends that field to OUT_W bits in one of four modes: sign, zero, load-upper, or prefix.
//  Prefix mode builds a 2*IN_W-bit immediate from two consecutive inputs.
//  Valid/ready on both sides with one output register stage. Replaces the combinational
//  Sign_Extend block.
// PARAMETERS
//  NIB_W   4    width of each of upper and lower; IN_W = 2*NIB_W
//  OUT_W   16   output immediate width; must satisfy OUT_W >= 4*NIB_W (2*IN_W)
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  upper          in   NIB_W   high field bits
//  lower          in   NIB_W   low field bits; field = {upper,lower}
//  mode           in   2       00 SEXT, 01 ZEXT, 10 LUI, 11 PREFIX
//  in_valid       in   1       upper/lower/mode valid
//  in_ready       out  1       unit accepts input this cycle
//  imme           out  OUT_W   extended immediate
//  out_valid      out  1       imme valid
//  out_ready      in   1       consumer takes imme this cycle
//  prefix_pending out  1       a PREFIX field is held and awaits its partner
// BEHAVIOUR
//  Reset (reset=0, async)
//   - imme=0, out_valid=0, prefix_pending=0, state=S_IDLE, prefix register=0.
//   - in_ready is combinational and reads 1 once reset is released.
//  Handshake
//   - in_ready = !out_valid || out_ready, so in_ready does not depend on in_valid.
//   - An input is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
//   - While out_valid=1 and out_ready=0, imme and out_valid hold stable.
//   - Accept and drain in the same cycle is allowed: throughput is 1 per cycle, latency is 1 cycle.
//  Extension, S_IDLE, f = {upper,lower}
//   - SEXT: imme = f sign-extended to OUT_W.
//   - ZEXT: imme = f zero-extended.
//   - LUI:  imme = f << IN_W, zero-filled, then zero-extended to OUT_W.
//   - PREFIX: f goes to the prefix register, state -> S_PREFIX, no output (out_valid unchanged by this input).
//  State machine
//   - S_IDLE -> S_PREFIX on an accepted PREFIX.
//   - S_PREFIX -> S_IDLE on an accepted non-PREFIX input.
//  S_PREFIX, c = {prefix,f} (2*IN_W bits)
//   - SEXT: imme = c sign-extended.
//   - ZEXT or LUI: imme = c zero-extended.
//   - Back to S_IDLE, prefix register cleared.
//   - A second PREFIX while in S_PREFIX overwrites the prefix register (last one wins) and gives no output.
//  prefix_pending = (state==S_PREFIX).
//  Boundary conditions
//   - Backpressure with a prefix pending: the prefix is held indefinitely.
//   - reset asserted mid-sequence drops the pending prefix and any undelivered imme.
//   - in_valid=1 while in_ready=0: the input is not consumed. The producer holds its fields and the unit ignores them.
// STRUCTURE
//  Shared package imm_pkg:
//   - mode localparams IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_PREFIX.
//   - state encoding S_IDLE=0, S_PREFIX=1.
//  Sub-module imm_ext_core: pure combinational extender (field, prefix, state, mode -> value).
//  Top level: FSM, prefix register, output register and handshake.
// TESTING (NIB_W=4, OUT_W=16; out_ready=1 unless stated)
//  1 SEXT u=1 l=0 -> 0x0010. SEXT u=8 l=0 -> 0xFF80. SEXT u=F l=F -> 0xFFFF. Each appears 1 cycle after accept.
//  2 ZEXT u=F l=0 -> 0x00F0. LUI u=1 l=2 -> 0x1200. ZEXT u=0 l=6 -> 0x0006.
//  3 PREFIX 0x12, then SEXT 0x34 -> exactly one output, 0x1234.
//    PREFIX 0x80, then SEXT 0x01 -> 0x8001.
//    PREFIX 0x80, then ZEXT 0x01 -> 0x8001, prefix_pending 1->0.
//  4 PREFIX 0xAB, then PREFIX 0x12, then SEXT 0x34 -> single output 0x1234.
//  5 Back-to-back SEXT inputs with out_ready=0 for 3 cycles -> first imme held stable, in_ready=0.
//    Release out_ready -> all values delivered in order, none lost or duplicated.
//  6 PREFIX 0x55, then pulse reset low -> prefix_pending=0, out_valid=0.
//    Next SEXT 0x7F -> 0x007F.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate extension unit: operating modes and
// the two-state prefix FSM encoding.
package imm_pkg;

  localparam logic [1:0] IMM_SEXT   = 2'b00;
  localparam logic [1:0] IMM_ZEXT   = 2'b01;
  localparam logic [1:0] IMM_LUI    = 2'b10;
  localparam logic [1:0] IMM_PREFIX = 2'b11;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_PREFIX = 1'b1;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: turns the joined field (and a held prefix, when one
// is pending) into the OUT_W-bit immediate for the selected mode.
import imm_pkg::*;

module imm_ext_core #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  field,
  input  logic [IN_W-1:0]  prefix,
  input  logic [0:0]       state,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] value
);

  logic [2*IN_W-1:0] combined;

  assign combined = {prefix, field};

  // Fill the upper bits first and then overlay the payload, which avoids
  // zero-width replications when OUT_W equals 2*IN_W.
  always_comb begin
    value = '0;
    if (state == S_IDLE) begin
      case (mode)
        IMM_SEXT: begin
          value = {OUT_W{field[IN_W-1]}};
          value[IN_W-1:0] = field;
        end
        IMM_ZEXT: value[IN_W-1:0] = field;
        IMM_LUI:  value[2*IN_W-1:IN_W] = field;
        default:  value = '0;
      endcase
    end else begin
      case (mode)
        IMM_SEXT: begin
          value = {OUT_W{combined[2*IN_W-1]}};
          value[2*IN_W-1:0] = combined;
        end
        IMM_ZEXT, IMM_LUI: value[2*IN_W-1:0] = combined;
        default:           value = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate generator: prefix FSM, output register and
// valid/ready handshake around the combinational extender.
import imm_pkg::*;

module imm_extend_unit #(
  parameter int NIB_W = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIB_W-1:0] upper,
  input  logic [NIB_W-1:0] lower,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] imme,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             prefix_pending
);

  localparam int IN_W = 2 * NIB_W;

  logic [0:0]       state;
  logic [IN_W-1:0]  prefix_q;
  logic [IN_W-1:0]  field;
  logic [OUT_W-1:0] ext_value;
  logic             accept;

  assign field          = {upper, lower};
  assign in_ready       = !out_valid || out_ready;
  assign accept         = in_valid && in_ready;
  assign prefix_pending = (state == S_PREFIX);

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .field  (field),
    .prefix (prefix_q),
    .state  (state),
    .mode   (mode),
    .value  (ext_value)
  );

  // A drain and an accept may share a cycle; a PREFIX input only drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      prefix_q  <= '0;
      imme      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (mode == IMM_PREFIX) begin
          prefix_q <= field;
          state    <= S_PREFIX;
        end else begin
          imme      <= ext_value;
          out_valid <= 1'b1;
          prefix_q  <= '0;
          state     <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: vector table for single transfers plus
// hand-written backpressure, prefix-hold and reset sequences.
import imm_pkg::*;

module tb_imm_extend_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  upper;
  logic [3:0]  lower;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imme;
  logic        out_valid;
  logic        out_ready;
  logic        prefix_pending;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] got[$];

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  upper;
    logic [3:0]  lower;
    logic        exp_valid;
    logic [15:0] exp_imme;
    logic        exp_pend;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  imm_extend_unit #(
    .NIB_W (4),
    .OUT_W (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .upper          (upper),
    .lower          (lower),
    .mode           (mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .imme           (imme),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .prefix_pending (prefix_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer in order.
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) got.push_back(imme);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] u, input logic [3:0] l);
    @(negedge clk);
    mode     = m;
    upper    = u;
    lower    = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{IMM_SEXT,   4'h1, 4'h0, 1'b1, 16'h0010, 1'b0};
    vecs[1]  = '{IMM_SEXT,   4'h8, 4'h0, 1'b1, 16'hFF80, 1'b0};
    vecs[2]  = '{IMM_SEXT,   4'hF, 4'hF, 1'b1, 16'hFFFF, 1'b0};
    vecs[3]  = '{IMM_ZEXT,   4'hF, 4'h0, 1'b1, 16'h00F0, 1'b0};
    vecs[4]  = '{IMM_LUI,    4'h1, 4'h2, 1'b1, 16'h1200, 1'b0};
    vecs[5]  = '{IMM_ZEXT,   4'h0, 4'h6, 1'b1, 16'h0006, 1'b0};
    vecs[6]  = '{IMM_PREFIX, 4'h1, 4'h2, 1'b0, 16'h0000, 1'b1};
    vecs[7]  = '{IMM_SEXT,   4'h3, 4'h4, 1'b1, 16'h1234, 1'b0};
    vecs[8]  = '{IMM_PREFIX, 4'h8, 4'h0, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{IMM_SEXT,   4'h0, 4'h1, 1'b1, 16'h8001, 1'b0};
    vecs[10] = '{IMM_PREFIX, 4'h8, 4'h0, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{IMM_ZEXT,   4'h0, 4'h1, 1'b1, 16'h8001, 1'b0};
    vecs[12] = '{IMM_PREFIX, 4'hA, 4'hB, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{IMM_PREFIX, 4'h1, 4'h2, 1'b0, 16'h0000, 1'b1};
    vecs[14] = '{IMM_SEXT,   4'h3, 4'h4, 1'b1, 16'h1234, 1'b0};
    vecs[15] = '{IMM_PREFIX, 4'hF, 4'hF, 1'b0, 16'h0000, 1'b1};
    vecs[16] = '{IMM_LUI,    4'h0, 4'h0, 1'b1, 16'hFF00, 1'b0};
    vecs[17] = '{IMM_SEXT,   4'h7, 4'hF, 1'b1, 16'h007F, 1'b0};

    reset     = 1'b0;
    upper     = '0;
    lower     = '0;
    mode      = IMM_SEXT;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset imme", imme, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset prefix_pending", prefix_pending, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("post-reset in_ready", in_ready, 1);

    // Single-transfer vectors with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].upper, vecs[i].lower);
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) checkOutput($sformatf("vec%0d imme", i), imme, vecs[i].exp_imme);
      checkOutput($sformatf("vec%0d prefix_pending", i), prefix_pending, vecs[i].exp_pend);
    end
    @(posedge clk);
    #1;
    checkOutput("single output after vectors", out_valid, 0);

    // Backpressure: first value held while more inputs wait, then all drain in order.
    got.delete();
    out_ready = 1'b0;
    applyStimulus(IMM_SEXT, 4'h0, 4'h1);
    checkOutput("bp first out_valid", out_valid, 1);
    checkOutput("bp first imme", imme, 16'h0001);
    @(negedge clk);
    mode     = IMM_SEXT;
    upper    = 4'h0;
    lower    = 4'h2;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp stall%0d in_ready", k), in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp stall%0d imme", k), imme, 16'h0001);
      checkOutput($sformatf("bp stall%0d out_valid", k), out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("bp second imme", imme, 16'h0002);
    @(negedge clk);
    lower = 4'h3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp third imme", imme, 16'h0003);
    @(posedge clk);
    #1;
    checkOutput("bp drained out_valid", out_valid, 0);
    checkOutput("bp transfer count", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      checkOutput($sformatf("bp transfer%0d", k), got[k], k + 1);

    // Prefix survives an idle, backpressured stretch.
    applyStimulus(IMM_PREFIX, 4'h1, 4'h2);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d prefix_pending", k), prefix_pending, 1);
    end
    applyStimulus(IMM_SEXT, 4'h3, 4'h4);
    checkOutput("hold joined imme", imme, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("hold stable imme", imme, 16'h1234);
    checkOutput("hold stable out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold drained out_valid", out_valid, 0);

    // Reset mid-sequence drops an undelivered output and a pending prefix.
    out_ready = 1'b0;
    applyStimulus(IMM_SEXT, 4'h0, 4'h9);
    checkOutput("rst pre out_valid", out_valid, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst drop out_valid", out_valid, 0);
    checkOutput("rst drop imme", imme, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(IMM_PREFIX, 4'h5, 4'h5);
    checkOutput("rst prefix_pending set", prefix_pending, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst prefix_pending cleared", prefix_pending, 0);
    checkOutput("rst out_valid cleared", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(IMM_SEXT, 4'h7, 4'hF);
    checkOutput("after rst imme", imme, 16'h007F);
    checkOutput("after rst out_valid", out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
